// File: rtl/bus_ctrl_pkg.sv
// ============================================================================
// Module      : bus_ctrl_pkg
// Description : Shared FSM state encoding and slave register addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5
  } state_e;

  localparam logic [31:0] ADDR_START = 32'd0;
  localparam logic [31:0] ADDR_OP_A  = 32'd1;
  localparam logic [31:0] ADDR_OP_B  = 32'd2;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_2.sv
// ============================================================================
// Module      : rr_arbiter_2
// Description : Two-way combinational round-robin arbiter, one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      // On a tie the requester that was not served last wins.
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bus_master_arbiter.sv
// ============================================================================
// Module      : bus_master_arbiter
// Description : Arbitrates two requesters onto a slave multiplier register bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_master_arbiter
  import bus_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] op_a0,
  input  logic [DATA_W-1:0] op_b0,
  input  logic [DATA_W-1:0] op_a1,
  input  logic [DATA_W-1:0] op_b1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic              s_valid,
  output logic              s_start,
  output logic [31:0]       s_address,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_result
);

  // Counter value seen on the last permitted WAIT cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [1:0]        gnt_q;
  logic [1:0]        done_q;
  logic              err_q;
  logic [DATA_W-1:0] result_q;
  logic              last_q;
  logic [7:0]        cnt_q;
  logic [DATA_W-1:0] opa_q, opb_q;
  logic [1:0]        arb_gnt;

  rr_arbiter_2 u_arb (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (arb_gnt)
  );

  always_comb begin
    state_d   = state_q;
    s_valid   = 1'b0;
    s_start   = 1'b0;
    s_address = ADDR_START;
    s_wdata   = '0;
    case (state_q)
      IDLE:   if (req != 2'b00) state_d = LOAD_A;
      LOAD_A: begin
        s_valid   = 1'b1;
        s_address = ADDR_OP_A;
        s_wdata   = opa_q;
        state_d   = LOAD_B;
      end
      LOAD_B: begin
        s_valid   = 1'b1;
        s_address = ADDR_OP_B;
        s_wdata   = opb_q;
        state_d   = START;
      end
      START: begin
        s_valid = 1'b1;
        s_start = 1'b1;
        state_d = WAIT;
      end
      WAIT:   if (s_ready || (cnt_q == TIMEOUT_LAST)) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      err_q    <= 1'b0;
      result_q <= '0;
      last_q   <= 1'b1;
      cnt_q    <= 8'd0;
      opa_q    <= '0;
      opb_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req != 2'b00) begin
            gnt_q <= arb_gnt;
            opa_q <= arb_gnt[1] ? op_a1 : op_a0;
            opb_q <= arb_gnt[1] ? op_b1 : op_b0;
          end
        end
        START: cnt_q <= 8'd0;
        WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          // A ready on the final cycle takes precedence over the timeout.
          if (s_ready) begin
            result_q <= s_result;
            err_q    <= 1'b0;
            done_q   <= gnt_q;
          end else if (cnt_q == TIMEOUT_LAST) begin
            result_q <= '0;
            err_q    <= 1'b1;
            done_q   <= gnt_q;
          end
        end
        DONE: begin
          done_q <= 2'b00;
          gnt_q  <= 2'b00;
          last_q <= gnt_q[1];
        end
        default: ;
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_master_arbiter.sv
// ============================================================================
// Module      : tb_bus_master_arbiter
// Description : Directed self-checking bench for bus_master_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_master_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [31:0] op_a0, op_b0, op_a1, op_b1;
  logic [1:0]  gnt, done;
  logic        err;
  logic [31:0] result;
  logic        s_valid, s_start;
  logic [31:0] s_address, s_wdata;
  logic        s_ready;
  logic [31:0] s_result;

  int checks = 0;
  int errors = 0;

  // Observations of the most recent transaction.
  logic [1:0]  tx_g, tx_d;
  logic        tx_e;
  logic [31:0] tx_r, tx_wa, tx_wb;
  int          tx_lat, tx_nwait;
  logic        tx_start_ok;
  logic        late_en;
  logic [31:0] late_val;

  always #5 clk = ~clk;

  bus_master_arbiter #(.DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .req(req),
    .op_a0(op_a0), .op_b0(op_b0), .op_a1(op_a1), .op_b1(op_b1),
    .gnt(gnt), .done(done), .err(err), .result(result),
    .s_valid(s_valid), .s_start(s_start), .s_address(s_address), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_result(s_result)
  );

  // Slave model: follows the bus, returns op_a*op_b, asserts ready on WAIT cycle ready_cyc (0 = never).
  task automatic run_txn(input int ready_cyc);
    int  gcnt = 0;
    bit  seen_done = 0;
    tx_g = 0; tx_d = 0; tx_e = 0; tx_r = 0; tx_wa = 0; tx_wb = 0;
    tx_lat = 0; tx_nwait = 0; tx_start_ok = 0;
    for (int c = 0; c < 100 && !seen_done; c++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        gcnt++;
        if (tx_g == 2'b00) tx_g = gnt;
      end
      if (done != 2'b00) begin
        tx_d = done; tx_e = err; tx_r = result; tx_lat = gcnt;
        seen_done = 1; s_ready = 1'b0;
      end else if (s_valid && !s_start && s_address == 32'd1) begin
        tx_wa = s_wdata;
      end else if (s_valid && !s_start && s_address == 32'd2) begin
        tx_wb = s_wdata;
        if (late_en) op_a0 = late_val;
      end else if (s_valid && s_start) begin
        tx_start_ok = (s_address == 32'd0) && (s_wdata == 32'd0);
      end else if (gnt != 2'b00) begin
        tx_nwait++;
        s_result = tx_wa * tx_wb;
        s_ready  = (tx_nwait == ready_cyc);
      end
    end
    if (!seen_done) begin
      checks++; errors++;
      $display("FAIL txn_bound: no done within 100 cycles (gnt=%b)", gnt);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 2'b00; s_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    op_a0 = 0; op_b0 = 0; op_a1 = 0; op_b1 = 0; s_result = 32'hDEAD_BEEF;
    late_en = 0; late_val = 0;
    do_reset();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", done); end
    checks++; if (err !== 1'b0 || result !== 32'd0) begin errors++; $display("FAIL reset_err_result: got %b/%0d want 0/0", err, result); end
    checks++; if ({s_valid, s_start} !== 2'b00 || s_address !== 0 || s_wdata !== 0) begin
      errors++; $display("FAIL reset_bus: got v=%b st=%b a=%0d d=%0d want all 0", s_valid, s_start, s_address, s_wdata);
    end
  endtask

  task automatic test_single();
    op_a0 = 6; op_b0 = 7; req = 2'b01;
    run_txn(1);
    req = 2'b00;
    checks++; if (tx_g !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b want 01", tx_g); end
    checks++; if (tx_wa !== 6 || tx_wb !== 7) begin errors++; $display("FAIL single_wdata: got %0d/%0d want 6/7", tx_wa, tx_wb); end
    checks++; if (tx_start_ok !== 1'b1) begin errors++; $display("FAIL single_start: got %b want 1", tx_start_ok); end
    checks++; if (tx_d !== 2'b01 || tx_lat !== 5) begin errors++; $display("FAIL single_done: got %b lat %0d want 01 lat 5", tx_d, tx_lat); end
    checks++; if (tx_r !== 42 || tx_e !== 1'b0) begin errors++; $display("FAIL single_result: got %0d err %b want 42 err 0", tx_r, tx_e); end
    @(negedge clk);
    checks++; if (gnt !== 2'b00 || done !== 2'b00 || s_valid !== 1'b0 || result !== 42) begin
      errors++; $display("FAIL single_after: got gnt=%b done=%b v=%b r=%0d want 00/00/0/42", gnt, done, s_valid, result);
    end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_g [3];
    logic [31:0] exp_r [3];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    exp_r[0] = 6;     exp_r[1] = 20;    exp_r[2] = 6;
    do_reset();
    op_a0 = 2; op_b0 = 3; op_a1 = 4; op_b1 = 5; req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      run_txn(1);
      checks++; if (tx_g !== exp_g[i] || tx_d !== exp_g[i]) begin
        errors++; $display("FAIL contention_gnt%0d: got gnt %b done %b want %b", i, tx_g, tx_d, exp_g[i]);
      end
      checks++; if (tx_r !== exp_r[i]) begin errors++; $display("FAIL contention_result%0d: got %0d want %0d", i, tx_r, exp_r[i]); end
      if (i == 2) req = 2'b00;
      @(negedge clk);
      checks++; if (gnt !== 2'b00 || s_valid !== 1'b0) begin
        errors++; $display("FAIL contention_idle%0d: got gnt %b v %b want 00 0", i, gnt, s_valid);
      end
    end
  endtask

  task automatic test_timeout();
    op_a0 = 11; op_b0 = 13; req = 2'b01;
    run_txn(0);
    req = 2'b00;
    checks++; if (tx_nwait !== 16) begin errors++; $display("FAIL timeout_cycles: got %0d want 16", tx_nwait); end
    checks++; if (tx_e !== 1'b1 || tx_r !== 0 || tx_d !== 2'b01) begin
      errors++; $display("FAIL timeout_result: got err %b r %0d done %b want 1 0 01", tx_e, tx_r, tx_d);
    end
    @(negedge clk);
  endtask

  task automatic test_coincide();
    op_a0 = 100; op_b0 = 12; req = 2'b01;
    run_txn(16);
    req = 2'b00;
    checks++; if (tx_nwait !== 16) begin errors++; $display("FAIL coincide_cycles: got %0d want 16", tx_nwait); end
    checks++; if (tx_e !== 1'b0 || tx_r !== 1200) begin errors++; $display("FAIL coincide_result: got err %b r %0d want 0 1200", tx_e, tx_r); end
    @(negedge clk);
  endtask

  task automatic test_op_change();
    op_a0 = 6; op_b0 = 7; req = 2'b01; late_en = 1; late_val = 9;
    run_txn(1);
    req = 2'b00; late_en = 0;
    checks++; if (tx_wa !== 6 || tx_r !== 42) begin errors++; $display("FAIL opchange: got a=%0d r=%0d want 6 42", tx_wa, tx_r); end
    op_a0 = 6;
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    bit in_wait = 0;
    op_a1 = 4; op_b1 = 5; req = 2'b10;
    for (int c = 0; c < 20 && !in_wait; c++) begin
      @(negedge clk);
      in_wait = (gnt != 2'b00) && !s_valid && (done == 2'b00);
    end
    checks++; if (!in_wait) begin errors++; $display("FAIL rstwait_reach: got no WAIT want WAIT"); end
    rst = 1'b1; req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (gnt !== 0 || done !== 0 || err !== 0 || result !== 0 || s_valid !== 0 || s_start !== 0 || s_address !== 0 || s_wdata !== 0) begin
      errors++; $display("FAIL rstwait_outputs: got gnt=%b done=%b err=%b r=%0d v=%b want all 0", gnt, done, err, result, s_valid);
    end
    @(negedge clk);
    checks++; if (done !== 2'b00) begin errors++; $display("FAIL rstwait_nodone: got %b want 00", done); end
    op_a0 = 3; op_b0 = 3; req = 2'b11;
    run_txn(1);
    req = 2'b00;
    checks++; if (tx_g !== 2'b01 || tx_r !== 9) begin errors++; $display("FAIL rstwait_tie: got gnt %b r %0d want 01 9", tx_g, tx_r); end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; s_ready = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_coincide();
    test_op_change();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_master_arbiter.md
BUS_MASTER_ARBITER -- requirements
Module: bus_master_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, width of operands, write data and result.
REQ-002 Parameter: TIMEOUT_CYC, 16, maximum WAIT cycles before abort; legal range 1..255.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req[1:0]  input  2  per-requester multiply request; held high until that requester's done.
REQ-006 op_a0, op_b0  input  DATA_W each  requester 0 operands.
REQ-007 op_a1, op_b1  input  DATA_W each  requester 1 operands.
REQ-008 gnt[1:0]  output  2  one-hot; high for the whole transaction of the served requester.
REQ-009 done[1:0]  output  2  one-cycle completion pulse to the served requester.
REQ-010 err  output  1  valid with done; 1 = timeout abort.
REQ-011 result  output  DATA_W  product; valid while done is high, held until the next done.
REQ-012 s_valid  output  1  slave bus valid.
REQ-013 s_start  output  1  slave bus start.
REQ-014 s_address  output  32  slave bus address.
REQ-015 s_wdata  output  DATA_W  operand data to the slave register file.
REQ-016 s_ready  input  1  slave completion flag.
REQ-017 s_result  input  DATA_W  slave product.

Function
REQ-018 FSM states SHALL be IDLE, LOAD_A, LOAD_B, START, WAIT, DONE; every state except IDLE and WAIT lasts exactly one cycle.
REQ-019 IDLE: if req!=0, arbitrate, latch the winner's operands, set gnt, go to LOAD_A; otherwise stay in IDLE with all slave outputs 0.
REQ-020 Arbitration SHALL be round-robin: a lone requester wins; if both request, the requester not served last wins.
REQ-021 LOAD_A: s_valid=1, s_address=1, s_wdata=latched op_a, s_start=0.
REQ-022 LOAD_B: s_valid=1, s_address=2, s_wdata=latched op_b, s_start=0.
REQ-023 START: s_valid=1, s_start=1, s_address=0, s_wdata=0.
REQ-024 WAIT: s_valid=0, s_start=0; a cycle counter starts at 0 on entry and increments each cycle.
REQ-025 WAIT exits on the first cycle s_ready=1: capture s_result into result, clear err, go to DONE.
REQ-026 If the counter reaches TIMEOUT_CYC without s_ready, the block SHALL set result=0, err=1 and go to DONE; if s_ready and timeout coincide, s_ready wins.
REQ-027 DONE: pulse done[gnt index] for one cycle, update the last-served pointer, clear gnt the following cycle, return to IDLE.
REQ-028 Minimum transaction latency: grant to done is 5 cycles when s_ready arrives on the first WAIT cycle.
REQ-029 Operands are latched once in IDLE; later changes to op_* or req do not affect the transaction in flight.
REQ-030 A req dropped mid-transaction SHALL NOT abort it; done is still pulsed.
REQ-031 A new transaction SHALL NOT start in the DONE cycle; IDLE always lasts at least one cycle.
REQ-032 result is DATA_W bits and is passed through from s_result without modification.

Reset
REQ-033 With rst high at a clock edge: state=IDLE; gnt, done, err, result, s_valid, s_start, s_address, s_wdata and the counter = 0; last-served pointer = 1, so requester 0 wins the first tie.
REQ-034 Reset asserted mid-transaction SHALL abort the transaction without a done pulse; slave outputs return to 0 on the next edge.

Structure
REQ-035 Package bus_ctrl_pkg SHALL hold the state enum and the address constants ADDR_START=0, ADDR_OP_A=1, ADDR_OP_B=2.
REQ-036 Arbitration SHALL be one sub-module, rr_arbiter_2 (req[1:0], last-served pointer, one-hot grant), combinational.

Verification
REQ-037 Single request: req=01, op_a0=6, op_b0=7; slave returns ready with 42 on the first WAIT cycle -> bus sequence addr 1/6, addr 2/7, addr 0 with start; done=01 five cycles after gnt; result=42; err=0.
REQ-038 Contention: req=11 from reset -> requester 0 served first, then requester 1; with req=11 held throughout, grants alternate 0,1,0.
REQ-039 Timeout: s_ready held 0, TIMEOUT_CYC=16 -> done after 16 WAIT cycles; err=1; result=0.
REQ-040 Coincidence: s_ready=1 on WAIT cycle 16 -> err=0; result=s_result.
REQ-041 Reset in WAIT: rst pulsed -> no done pulse, all outputs 0, next tie goes to requester 0.
REQ-042 Operand change: op_a0 changes from 6 to 9 during LOAD_B -> s_wdata in LOAD_A was 6; result is still 6*op_b0.
